mem_port_arbiter: RTL and testbench

- Shares the single-ported instruction/data SRAM between two requesters: the fetch stage (read-only) and the memory stage (read/write).
- Serialises requests and sequences each access through a fixed SRAM read latency.
- Returns data to the winning requester and holds the loser with a wait signal, which the pipeline ORs into its stall network.
- Sits between the pipeline stages and the SRAM macro.

---
 rtl/mc_pkg.sv | 19 +
 rtl/mc_rr_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings and defaults for the SRAM port arbiter
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;

  localparam int DEF_ADDR_W  = 18;
  localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/mc_rr_pick.sv
// rtl/mc_rr_pick.sv - two-input picker, memory stage first, alternating only on conflict
module mc_rr_pick
  import mc_pkg::*;
(
  input  logic req_if,
  input  logic req_mem,
  input  gnt_t last_grant,
  output gnt_t grant,
  output logic any
);

  assign any = req_if | req_mem;

  always_comb begin
    grant = GNT_IF;
    if (req_mem && !(req_if && last_grant == GNT_MEM)) grant = GNT_MEM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and memory-stage accesses onto one SRAM port
module mem_port_arbiter
  import mc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_en,
  input  logic [31:0]       if_mc_addr,
  output logic [31:0]       mc_if_data,
  output logic              mc_if_valid,
  output logic              mc_if_wait,
  input  logic              mem_mc_en,
  input  logic              mem_mc_we,
  input  logic [31:0]       mem_mc_addr,
  input  logic [31:0]       mem_mc_wdata,
  output logic [31:0]       mc_mem_data,
  output logic              mc_mem_valid,
  output logic              mc_mem_wait,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] LAT = 3'(LATENCY);

  state_t     state;
  gnt_t       gnt;
  gnt_t       last_grant;
  gnt_t       pick;
  logic       any;
  logic       rd_op;
  logic [2:0] cnt;
  logic       unused_addr_bits;

  mc_rr_pick u_pick (
    .req_if     (if_mc_en),
    .req_mem    (mem_mc_en),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (any)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign mc_if_wait  = reset & if_mc_en  & ~mc_if_valid;
  assign mc_mem_wait = reset & mem_mc_en & ~mc_mem_valid;

  assign unused_addr_bits = ^{if_mc_addr[31:ADDR_W+2], if_mc_addr[1:0],
                              mem_mc_addr[31:ADDR_W+2], mem_mc_addr[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      gnt          <= GNT_IF;
      last_grant   <= GNT_IF;
      rd_op        <= 1'b0;
      cnt          <= '0;
      mc_if_data   <= '0;
      mc_if_valid  <= 1'b0;
      mc_mem_data  <= '0;
      mc_mem_valid <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      mc_if_valid  <= 1'b0;
      mc_mem_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt        <= pick;
            last_grant <= pick;
            ram_en     <= 1'b1;
            state      <= ST_ISSUE;
            if (pick == GNT_MEM) begin
              rd_op     <= ~mem_mc_we;
              ram_we    <= mem_mc_we;
              ram_addr  <= mem_mc_addr[ADDR_W+1:2];
              ram_wdata <= mem_mc_wdata;
            end else begin
              rd_op    <= 1'b1;
              ram_addr <= if_mc_addr[ADDR_W+1:2];
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= 3'd1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAT) begin
            state <= ST_DONE;
            // Valid is raised here so it is high during DONE, alongside the captured data.
            if (gnt == GNT_IF) begin
              mc_if_valid <= 1'b1;
              if (rd_op) mc_if_data <= ram_rdata;
            end else begin
              mc_mem_valid <= 1'b1;
              if (rd_op) mc_mem_data <= ram_rdata;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW    = 18;
  localparam int LAT   = 2;
  localparam int WIN   = LAT + 6;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_mc_en = 1'b0;
  logic [31:0]   if_mc_addr = '0;
  logic [31:0]   mc_if_data;
  logic          mc_if_valid;
  logic          mc_if_wait;
  logic          mem_mc_en = 1'b0;
  logic          mem_mc_we = 1'b0;
  logic [31:0]   mem_mc_addr = '0;
  logic [31:0]   mem_mc_wdata = '0;
  logic [31:0]   mc_mem_data;
  logic          mc_mem_valid;
  logic          mc_mem_wait;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mc_if_valid  (mc_if_valid),
    .mc_if_wait   (mc_if_wait),
    .mem_mc_en    (mem_mc_en),
    .mem_mc_we    (mem_mc_we),
    .mem_mc_addr  (mem_mc_addr),
    .mem_mc_wdata (mem_mc_wdata),
    .mc_mem_data  (mc_mem_data),
    .mc_mem_valid (mc_mem_valid),
    .mc_mem_wait  (mc_mem_wait),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM macro stand-in: returns garbage except exactly LAT cycles after a read strobe.
  logic [31:0] sram    [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] pipe    [LAT];

  always @(posedge clock) begin
    if (ram_en && ram_we) sram[int'(ram_addr)] <= ram_wdata;
    pipe[0] <= (ram_en && !ram_we) ? sram[int'(ram_addr)] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  logic [31:0]   exp_if_data  = '0;
  logic [31:0]   exp_mem_data = '0;
  int            o_ten, o_tval, o_nen, o_nval, o_nother, o_waitbad;
  logic [AW-1:0] o_addr;
  logic          o_we;
  logic [31:0]   o_wdata, o_data;

  task automatic do_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit drop);
    bit held;
    o_ten = -1; o_tval = -1; o_nen = 0; o_nval = 0; o_nother = 0; o_waitbad = 0;
    o_addr = '0; o_we = 1'b0; o_wdata = '0; o_data = '0;
    if (is_mem) begin
      mem_mc_en = 1'b1; mem_mc_we = we; mem_mc_addr = addr; mem_mc_wdata = wdata;
    end else begin
      if_mc_en = 1'b1; if_mc_addr = addr;
    end
    held = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clock);
      if (ram_en) begin
        o_nen++;
        if (o_ten < 0) begin
          o_ten = k; o_addr = ram_addr; o_we = ram_we; o_wdata = ram_wdata;
        end
      end
      if (is_mem ? mc_mem_valid : mc_if_valid) begin
        o_nval++;
        if (o_tval < 0) begin
          o_tval = k;
          o_data = is_mem ? mc_mem_data : mc_if_data;
        end
      end
      if (is_mem ? mc_if_valid : mc_mem_valid) o_nother++;
      if ((is_mem ? mc_mem_wait : mc_if_wait) !== (held && k != LAT + 2)) o_waitbad++;
      if (k == LAT + 2 || (drop && k == 1)) begin
        held = 1'b0; if_mc_en = 1'b0; mem_mc_en = 1'b0;
      end
    end
    if (is_mem && we) ref_mem[widx(addr)] = wdata;
    else if (is_mem) exp_mem_data = ref_mem[widx(addr)];
    else exp_if_data = ref_mem[widx(addr)];
  endtask

  task automatic test_reset();
    reset = 1'b0; if_mc_en = 1'b1; mem_mc_en = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({mc_if_valid, mc_if_wait, mc_mem_valid, mc_mem_wait, ram_en, ram_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 000000",
               {mc_if_valid, mc_if_wait, mc_mem_valid, mc_mem_wait, ram_en, ram_we});
    end
    n_cmp++;
    if ({mc_if_data, mc_mem_data, ram_wdata, ram_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h %h want all zero", mc_if_data, mc_mem_data, ram_wdata, ram_addr);
    end
    if_mc_en = 1'b0; mem_mc_en = 1'b0; reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (ram_en !== 1'b0) begin n_bad++; $display("FAIL idle_ram_en got %b want 0", ram_en); end
    exp_if_data = '0; exp_mem_data = '0;
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    sram[16] = 32'h8C01_0004; ref_mem[16] = 32'h8C01_0004;
    do_txn(1'b0, 1'b0, 32'h40, '0, 1'b0);
    n_cmp++; if (o_ten !== 1) begin n_bad++; $display("FAIL fetch_ram_en_cycle got %0d want 1", o_ten); end
    n_cmp++; if (o_nen !== 1) begin n_bad++; $display("FAIL fetch_ram_en_count got %0d want 1", o_nen); end
    n_cmp++; if (o_addr !== 18'h10) begin n_bad++; $display("FAIL fetch_ram_addr got %h want 10", o_addr); end
    n_cmp++; if (o_tval !== LAT + 2) begin n_bad++; $display("FAIL fetch_valid_cycle got %0d want %0d", o_tval, LAT + 2); end
    n_cmp++; if (o_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL fetch_data got %h want 8c010004", o_data); end
    n_cmp++; if (o_nval !== 1 || o_nother !== 0) begin n_bad++; $display("FAIL fetch_pulses got %0d/%0d want 1/0", o_nval, o_nother); end
    n_cmp++; if (o_waitbad !== 0) begin n_bad++; $display("FAIL fetch_wait got %0d bad cycles want 0", o_waitbad); end
    n_cmp++; if (mc_mem_data !== exp_mem_data) begin n_bad++; $display("FAIL fetch_mem_data_kept got %h want %h", mc_mem_data, exp_mem_data); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      do_txn(1'b0, 1'b0, a, '0, 1'b0);
      n_cmp++;
      if (o_data !== exp_if_data || o_addr !== a[AW+1:2] || o_tval !== LAT + 2) begin
        n_bad++;
        $display("FAIL fetch_rand data %h addr %h t %0d want %h %h %0d", o_data, o_addr, o_tval, exp_if_data, a[AW+1:2], LAT + 2);
      end
    end
  endtask

  task automatic test_mem_write_read();
    logic [31:0] a, d;
    bit          w;
    do_txn(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    n_cmp++; if (o_we !== 1'b1 || o_addr !== 18'h40) begin n_bad++; $display("FAIL wr_strobe got we %b addr %h want 1 40", o_we, o_addr); end
    n_cmp++; if (o_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_wdata got %h want deadbeef", o_wdata); end
    n_cmp++; if (o_nval !== 1 || o_tval !== LAT + 2) begin n_bad++; $display("FAIL wr_ack got %0d at %0d want 1 at %0d", o_nval, o_tval, LAT + 2); end
    n_cmp++; if (mc_mem_data !== exp_mem_data) begin n_bad++; $display("FAIL wr_data_kept got %h want %h", mc_mem_data, exp_mem_data); end
    do_txn(1'b1, 1'b0, 32'h100, '0, 1'b0);
    n_cmp++; if (o_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_after_wr got %h want deadbeef", o_data); end
    for (int i = 0; i < 8; i++) begin
      a = 32'h2000 | (32'($urandom_range(0, 3)) << 2);
      d = $urandom;
      w = 1'($urandom);
      if (i % 3 == 2) begin
        do_txn(1'b0, 1'b0, a, '0, 1'b0);
        n_cmp++;
        if (o_data !== exp_if_data) begin n_bad++; $display("FAIL mix_fetch got %h want %h", o_data, exp_if_data); end
      end else begin
        do_txn(1'b1, w, a, d, 1'b0);
        n_cmp++;
        if (w ? (o_we !== 1'b1 || o_wdata !== d) : (o_we !== 1'b0 || o_data !== exp_mem_data)) begin
          n_bad++;
          $display("FAIL mix_mem we %b got we %b wdata %h data %h want %h", w, o_we, o_wdata, o_data, w ? d : exp_mem_data);
        end
      end
    end
    n_cmp++;
    if (mc_if_data !== exp_if_data) begin n_bad++; $display("FAIL mix_if_data_kept got %h want %h", mc_if_data, exp_if_data); end
  endtask

  task automatic test_addr_alias();
    logic [31:0]   a1, a2;
    logic [AW-1:0] w, s1;
    logic [31:0]   d1;
    do_txn(1'b0, 1'b0, 32'h43, '0, 1'b0);
    n_cmp++; if (o_addr !== 18'h10 || o_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL alias_43 got %h %h want 10 8c010004", o_addr, o_data); end
    for (int i = 0; i < 3; i++) begin
      w  = AW'($urandom);
      a1 = {12'($urandom), w, 2'b11};
      a2 = {12'($urandom), w, 2'b00};
      do_txn(1'b0, 1'b0, a1, '0, 1'b0);
      s1 = o_addr; d1 = o_data;
      do_txn(1'b1, 1'b0, a2, '0, 1'b0);
      n_cmp++;
      if (s1 !== w || o_addr !== w || d1 !== o_data || o_data !== exp_mem_data) begin
        n_bad++;
        $display("FAIL alias_rand got %h %h %h %h want %h %h", s1, o_addr, d1, o_data, w, exp_mem_data);
      end
    end
  endtask

  task automatic test_drop_en();
    do_txn(1'b0, 1'b0, $urandom, '0, 1'b1);
    n_cmp++; if (o_nval !== 1) begin n_bad++; $display("FAIL drop_pulses got %0d want 1", o_nval); end
    n_cmp++; if (o_data !== exp_if_data) begin n_bad++; $display("FAIL drop_data got %h want %h", o_data, exp_if_data); end
    n_cmp++; if (o_waitbad !== 0) begin n_bad++; $display("FAIL drop_wait got %0d bad cycles want 0", o_waitbad); end
    do_txn(1'b0, 1'b0, $urandom, '0, 1'b0);
    n_cmp++;
    if (o_ten !== 1 || o_tval !== LAT + 2 || o_data !== exp_if_data) begin
      n_bad++;
      $display("FAIL drop_next got en %0d valid %0d data %h want 1 %0d %h", o_ten, o_tval, o_data, LAT + 2, exp_if_data);
    end
  endtask

  task automatic test_reset_mid();
    int nv, ne;
    if_mc_en = 1'b1; if_mc_addr = $urandom;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mc_if_valid, mc_if_wait, mc_mem_valid, mc_mem_wait, ram_en, ram_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL midrst_ctrl got %b want 000000",
               {mc_if_valid, mc_if_wait, mc_mem_valid, mc_mem_wait, ram_en, ram_we});
    end
    exp_if_data = '0; exp_mem_data = '0;
    n_cmp++;
    if ({mc_if_data, mc_mem_data, ram_addr, ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL midrst_data got %h %h %h %h want all zero", mc_if_data, mc_mem_data, ram_addr, ram_wdata);
    end
    if_mc_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    nv = 0; ne = 0;
    repeat (WIN) begin
      @(negedge clock);
      nv += int'(mc_if_valid);
      ne += int'(ram_en);
    end
    n_cmp++; if (nv !== 0 || ne !== 0) begin n_bad++; $display("FAIL midrst_ghost got valid %0d ram_en %0d want 0 0", nv, ne); end
    do_txn(1'b0, 1'b0, $urandom, '0, 1'b0);
    n_cmp++;
    if (o_tval !== LAT + 2 || o_data !== exp_if_data) begin
      n_bad++;
      $display("FAIL midrst_after got t %0d data %h want %0d %h", o_tval, o_data, LAT + 2, exp_if_data);
    end
  endtask

  task automatic test_arbitration();
    int n_done, t_if, t_mem;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_if_data = '0; exp_mem_data = '0;
    n_done = 0; t_if = 0; t_mem = 0;
    // Both requesters stay busy: each re-arms a fresh request the moment its valid is seen.
    if_mc_en = 1'b1; if_mc_addr = 32'h3000 | (32'($urandom_range(0, 3)) << 2);
    mem_mc_en = 1'b1; mem_mc_we = 1'($urandom); mem_mc_wdata = $urandom;
    mem_mc_addr = 32'h3000 | (32'($urandom_range(0, 3)) << 2);
    for (int cyc = 0; cyc < 400 && n_done < 8; cyc++) begin
      @(negedge clock);
      t_if++; t_mem++;
      if (mc_mem_valid) begin
        n_cmp++;
        if (n_done % 2 != 0 || mc_if_valid) begin n_bad++; $display("FAIL arb_order grant %0d got MEM want IF", n_done); end
        if (mem_mc_we) ref_mem[widx(mem_mc_addr)] = mem_mc_wdata;
        else begin
          exp_mem_data = ref_mem[widx(mem_mc_addr)];
          n_cmp++;
          if (mc_mem_data !== exp_mem_data) begin n_bad++; $display("FAIL arb_mem_data got %h want %h", mc_mem_data, exp_mem_data); end
        end
        n_cmp++;
        if (t_mem > 2 * (LAT + 3)) begin n_bad++; $display("FAIL arb_mem_wait got %0d want <= %0d", t_mem, 2 * (LAT + 3)); end
        mem_mc_we = 1'($urandom); mem_mc_wdata = $urandom;
        mem_mc_addr = 32'h3000 | (32'($urandom_range(0, 3)) << 2);
        t_mem = 0; n_done++;
      end else if (mc_if_valid) begin
        n_cmp++;
        if (n_done % 2 != 1) begin n_bad++; $display("FAIL arb_order grant %0d got IF want MEM", n_done); end
        exp_if_data = ref_mem[widx(if_mc_addr)];
        n_cmp++;
        if (mc_if_data !== exp_if_data) begin n_bad++; $display("FAIL arb_if_data got %h want %h", mc_if_data, exp_if_data); end
        n_cmp++;
        if (t_if > 2 * (LAT + 3)) begin n_bad++; $display("FAIL arb_if_wait got %0d want <= %0d", t_if, 2 * (LAT + 3)); end
        if_mc_addr = 32'h3000 | (32'($urandom_range(0, 3)) << 2);
        t_if = 0; n_done++;
      end
    end
    if_mc_en = 1'b0; mem_mc_en = 1'b0;
    n_cmp++;
    if (n_done !== 8) begin n_bad++; $display("FAIL arb_timeout got %0d grants want 8", n_done); end
    repeat (WIN) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
      ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    end
    test_reset();
    test_fetch();
    test_mem_write_read();
    test_addr_alias();
    test_drop_en();
    test_reset_mid();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
